// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared constants for the Needleman-Wunsch traceback path
// Purpose: symbol encoding, traceback-buffer state encoding, default sequence length.
// Ports: none (package).
package nw_pkg;

    localparam int N_DEFAULT = 128;
    localparam int SYM_W     = 3;

    localparam logic [SYM_W-1:0] SYM_A   = 3'd0;
    localparam logic [SYM_W-1:0] SYM_C   = 3'd1;
    localparam logic [SYM_W-1:0] SYM_G   = 3'd2;
    localparam logic [SYM_W-1:0] SYM_T   = 3'd3;
    localparam logic [SYM_W-1:0] SYM_GAP = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/al_ram_core.sv
// rtl/al_ram_core.sv - 1R1W synchronous RAM with registered read address
// Purpose: storage array for the aligned-symbol buffer; contents are not reset.
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i capture the read
//        address; rdata_o is the word at the captured address.
module al_ram_core #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    raddr_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/al_ram_stream.sv
// rtl/al_ram_stream.sv - traceback-order buffer replayed forward as a valid/ready stream
// Purpose: stores CH aligned-symbol channels written end-first, then streams them
//          start-first with rd_last on the final entry and a done pulse afterwards.
// Ports: clk, rst (sync, active-high); start; wr_en/wr_data/wr_last traceback input;
//        rd_valid/rd_ready/rd_data/rd_last output stream; len, full, ovf, busy, done status.
module al_ram_stream
    import nw_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = 2 * N,
    parameter int W     = SYM_W,
    parameter int CH    = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            wr_en,
    input  logic [CH*W-1:0] wr_data,
    input  logic            wr_last,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [CH*W-1:0] rd_data,
    output logic            rd_last,
    output logic [LW-1:0]   len,
    output logic            full,
    output logic            ovf,
    output logic            busy,
    output logic            done
);

    state_t state_q, state_d;

    logic [LW-1:0]   len_q;
    logic            ovf_q;
    logic            done_q;
    logic [AW-1:0]   rp_q;
    logic            issue_left_q;   // addresses remain to be issued to the RAM
    logic            pf_valid_q;     // RAM output holds a fetched entry
    logic            pf_last_q;      // that fetched entry is address 0
    logic            rd_valid_q;
    logic            rd_last_q;
    logic [CH*W-1:0] rd_data_q;
    logic [CH*W-1:0] core_rdata;

    logic          wr_ok;
    logic [LW-1:0] len_next;
    logic          fill_end;
    logic          xfer;
    logic          drain_end;
    logic          load_out;
    logic          issue;

    assign wr_ok     = (state_q == ST_FILL) && wr_en && !full;
    assign len_next  = len_q + LW'(wr_ok);
    assign fill_end  = (state_q == ST_FILL) && wr_last;
    assign xfer      = rd_valid_q && rd_ready;
    assign drain_end = xfer && rd_last_q;
    // Two-stage pipeline (RAM address, output register) advances whenever the
    // stage ahead is empty or being emptied this cycle.
    assign load_out  = pf_valid_q && (!rd_valid_q || rd_ready);
    assign issue     = (state_q == ST_DRAIN) && issue_left_q && (!pf_valid_q || load_out);

    al_ram_core #(
        .WIDTH (CH * W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (AW'(len_q)),
        .wdata_i (wr_data),
        .re_i    (issue),
        .raddr_i (rp_q),
        .rdata_o (core_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (wr_last) state_d = (len_next == '0) ? ST_DONE : ST_DRAIN;
                ST_DRAIN: if (drain_end) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_FILL) || (state_q == ST_DRAIN);
        full = (len_q == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            rp_q         <= '0;
            issue_left_q <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_last_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
        end else if (start) begin
            len_q        <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            issue_left_q <= 1'b0;
            pf_valid_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            done_q <= (state_q != ST_DONE) && (state_d == ST_DONE);

            if (wr_ok) begin
                len_q <= len_next;
            end
            if ((state_q == ST_FILL) && wr_en && full) begin
                ovf_q <= 1'b1;
            end

            if (fill_end) begin
                rp_q         <= AW'(len_next - LW'(1));
                issue_left_q <= (len_next != '0);
            end

            if (issue) begin
                pf_valid_q <= 1'b1;
                pf_last_q  <= (rp_q == '0);
                if (rp_q == '0) begin
                    issue_left_q <= 1'b0;
                end else begin
                    rp_q <= rp_q - AW'(1);
                end
            end else if (load_out) begin
                pf_valid_q <= 1'b0;
            end

            if (load_out) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= core_rdata;
                rd_last_q  <= pf_last_q;
            end else if (xfer) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_last  = rd_last_q;
    assign len      = len_q;
    assign ovf      = ovf_q;
    assign done     = done_q;

endmodule
